// File: rtl/int_core_handler.sv
// ----------------------------------------------------------------------------
// int_core_handler
//
// Interrupt entry/exit sequencer sitting between an interrupt controller and a
// simple core. On an enabled request it waits for an instruction boundary,
// pushes the return address, loads the vector address into the core PC and
// runs the handler. On RETI it pops the return address back into the PC.
// Nesting is not supported: requests are ignored while a handler runs.
//
// Optional feature (compile-time macro INT_MASK_EN):
//   Adds a 16-bit per-interrupt mask register (reset 16'hFFFF) written through
//   MASK_WE / MASK_DATA. A request is only accepted if its mask bit is set.
//   Without the macro, the mask ports and register do not exist.
//
// Parameters
//   PC_WIDTH            width of every program-counter path
//   VECTOR_BASE         address of the vector for interrupt 0
//   VECTOR_STRIDE_LOG2  log2 of the spacing between vector entries
//
// Ports
//   CLK             clock, rising edge
//   RESET           asynchronous reset, active low
//   INT2COR         level request from the interrupt controller
//   NUM_INT[3:0]    requesting interrupt number, valid with INT2COR
//   GIE             global interrupt enable
//   INSTR_DONE      core is at an instruction boundary
//   PC_IN           core return address, valid with INSTR_DONE
//   RETI            return-from-interrupt pulse from the core
//   STACK_READY     stack accepts the push / returns pop data this cycle
//   STACK_DATA_IN   pop data
//   MASK_WE         mask register write strobe        (INT_MASK_EN only)
//   MASK_DATA[15:0] mask register write data          (INT_MASK_EN only)
//   STACK_PUSH      push request, held until STACK_READY
//   STACK_POP       pop request, held until STACK_READY
//   STACK_DATA_OUT  saved return address
//   PC_LOAD         one-cycle pulse: core loads PC_OUT
//   PC_OUT          vector address or restored return address
//   CORE_STALL      core frozen while this block owns the PC
//   INT_ACK         one-cycle acknowledge to the source
//   IN_SERVICE      a handler is running
//   ACTIVE_NUM[3:0] number of the interrupt being serviced
// ----------------------------------------------------------------------------
// State table
//   state       | meaning
//   ------------+--------------------------------------------------------------
//   IDLE        | waiting for an enabled request
//   WAIT_BOUND  | request committed, waiting for an instruction boundary
//   PUSH        | pushing the return address, core stalled
//   VECTOR      | one cycle: load vector address, acknowledge source
//   SERVICE     | handler running, waiting for RETI
//   POP         | popping the return address, core stalled
//   RESTORE     | one cycle: load popped return address
// ----------------------------------------------------------------------------
module int_core_handler #(
    parameter int          PC_WIDTH           = 16,
    parameter int unsigned VECTOR_BASE        = 16'h0010,
    parameter int          VECTOR_STRIDE_LOG2 = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                INT2COR,
    input  logic [3:0]          NUM_INT,
    input  logic                GIE,
    input  logic                INSTR_DONE,
    input  logic [PC_WIDTH-1:0] PC_IN,
    input  logic                RETI,
    input  logic                STACK_READY,
    input  logic [PC_WIDTH-1:0] STACK_DATA_IN,
`ifdef INT_MASK_EN
    input  logic                MASK_WE,
    input  logic [15:0]         MASK_DATA,
`endif
    output logic                STACK_PUSH,
    output logic                STACK_POP,
    output logic [PC_WIDTH-1:0] STACK_DATA_OUT,
    output logic                PC_LOAD,
    output logic [PC_WIDTH-1:0] PC_OUT,
    output logic                CORE_STALL,
    output logic                INT_ACK,
    output logic                IN_SERVICE,
    output logic [3:0]          ACTIVE_NUM
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_BOUND = 3'd1;
    localparam logic [2:0] S_PUSH       = 3'd2;
    localparam logic [2:0] S_VECTOR     = 3'd3;
    localparam logic [2:0] S_SERVICE    = 3'd4;
    localparam logic [2:0] S_POP        = 3'd5;
    localparam logic [2:0] S_RESTORE    = 3'd6;

    logic [2:0]          state;
    logic [2:0]          state_nxt;
    logic [3:0]          active_num;
    logic [PC_WIDTH-1:0] ret_addr;
    logic [PC_WIDTH-1:0] pop_data;
    logic [PC_WIDTH-1:0] vec_addr;
    logic                req_ok;

`ifdef INT_MASK_EN
    logic [15:0] mask;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mask <= 16'hFFFF;
        end else if (MASK_WE) begin
            mask <= MASK_DATA;
        end
    end

    assign req_ok = INT2COR & GIE & mask[NUM_INT];
`else
    assign req_ok = INT2COR & GIE;
`endif

    // Sum is taken at PC_WIDTH so it wraps modulo 2^PC_WIDTH.
    assign vec_addr = PC_WIDTH'(VECTOR_BASE)
                    + (PC_WIDTH'(active_num) << VECTOR_STRIDE_LOG2);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (req_ok)      state_nxt = S_WAIT_BOUND;
            S_WAIT_BOUND: if (INSTR_DONE)  state_nxt = S_PUSH;
            S_PUSH:       if (STACK_READY) state_nxt = S_VECTOR;
            S_VECTOR:                      state_nxt = S_SERVICE;
            S_SERVICE:    if (RETI)        state_nxt = S_POP;
            S_POP:        if (STACK_READY) state_nxt = S_RESTORE;
            S_RESTORE:                     state_nxt = S_IDLE;
            default:                       state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= S_IDLE;
            active_num <= '0;
            ret_addr   <= '0;
            pop_data   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && req_ok) begin
                active_num <= NUM_INT;
            end
            // Only a boundary seen in WAIT_BOUND counts; one coinciding with
            // the request in IDLE is deliberately not captured.
            if (state == S_WAIT_BOUND && INSTR_DONE) begin
                ret_addr <= PC_IN;
            end
            if (state == S_POP && STACK_READY) begin
                pop_data <= STACK_DATA_IN;
            end
        end
    end

    // All control outputs decode straight from the state register so that an
    // asynchronous reset drops them in the same instant.
    always_comb begin
        PC_OUT = '0;
        case (state)
            S_VECTOR:  PC_OUT = vec_addr;
            S_RESTORE: PC_OUT = pop_data;
            default:   PC_OUT = '0;
        endcase
    end

    assign STACK_PUSH     = (state == S_PUSH);
    assign STACK_POP      = (state == S_POP);
    assign PC_LOAD        = (state == S_VECTOR) || (state == S_RESTORE);
    assign INT_ACK        = (state == S_VECTOR);
    assign IN_SERVICE     = (state == S_SERVICE);
    assign CORE_STALL     = (state == S_PUSH) || (state == S_VECTOR) ||
                            (state == S_POP)  || (state == S_RESTORE);
    assign STACK_DATA_OUT = ret_addr;
    assign ACTIVE_NUM     = active_num;

endmodule

// File: tb/tb_int_core_handler.sv
module tb_int_core_handler;

    typedef struct {
        logic        ack;
        logic [15:0] pc;
    } exp_t;

    logic        CLK;
    logic        RESET;
    logic        INT2COR;
    logic [3:0]  NUM_INT;
    logic        GIE;
    logic        INSTR_DONE;
    logic [15:0] PC_IN;
    logic        RETI;
    logic        STACK_READY;
    logic [15:0] STACK_DATA_IN;
`ifdef INT_MASK_EN
    logic        MASK_WE;
    logic [15:0] MASK_DATA;
`endif

    logic        STACK_PUSH, STACK_POP, PC_LOAD, CORE_STALL, INT_ACK, IN_SERVICE;
    logic [15:0] STACK_DATA_OUT, PC_OUT;
    logic [3:0]  ACTIVE_NUM;

    logic        STACK_PUSH8, STACK_POP8, PC_LOAD8, CORE_STALL8, INT_ACK8, IN_SERVICE8;
    logic [7:0]  STACK_DATA_OUT8, PC_OUT8;
    logic [3:0]  ACTIVE_NUM8;

    int n_vec = 0;
    int n_bad = 0;

    exp_t        q_pc[$];
    exp_t        q_pc8[$];
    logic [15:0] q_push[$];

    int_core_handler u_dut (
        .CLK(CLK), .RESET(RESET), .INT2COR(INT2COR), .NUM_INT(NUM_INT), .GIE(GIE),
        .INSTR_DONE(INSTR_DONE), .PC_IN(PC_IN), .RETI(RETI),
        .STACK_READY(STACK_READY), .STACK_DATA_IN(STACK_DATA_IN),
`ifdef INT_MASK_EN
        .MASK_WE(MASK_WE), .MASK_DATA(MASK_DATA),
`endif
        .STACK_PUSH(STACK_PUSH), .STACK_POP(STACK_POP), .STACK_DATA_OUT(STACK_DATA_OUT),
        .PC_LOAD(PC_LOAD), .PC_OUT(PC_OUT), .CORE_STALL(CORE_STALL), .INT_ACK(INT_ACK),
        .IN_SERVICE(IN_SERVICE), .ACTIVE_NUM(ACTIVE_NUM)
    );

    // Narrow instance for the vector wrap-around case, fed the same control.
    int_core_handler #(.PC_WIDTH(8), .VECTOR_BASE(8'hF0), .VECTOR_STRIDE_LOG2(2)) u_dut8 (
        .CLK(CLK), .RESET(RESET), .INT2COR(INT2COR), .NUM_INT(NUM_INT), .GIE(GIE),
        .INSTR_DONE(INSTR_DONE), .PC_IN(PC_IN[7:0]), .RETI(RETI),
        .STACK_READY(STACK_READY), .STACK_DATA_IN(STACK_DATA_IN[7:0]),
`ifdef INT_MASK_EN
        .MASK_WE(MASK_WE), .MASK_DATA(MASK_DATA),
`endif
        .STACK_PUSH(STACK_PUSH8), .STACK_POP(STACK_POP8), .STACK_DATA_OUT(STACK_DATA_OUT8),
        .PC_LOAD(PC_LOAD8), .PC_OUT(PC_OUT8), .CORE_STALL(CORE_STALL8), .INT_ACK(INT_ACK8),
        .IN_SERVICE(IN_SERVICE8), .ACTIVE_NUM(ACTIVE_NUM8)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_pc(input logic ack, input logic [15:0] pc16, input logic [7:0] pc8);
        exp_t e;
        e.ack = ack; e.pc = pc16;
        q_pc.push_back(e);
        e.pc = {8'h00, pc8};
        q_pc8.push_back(e);
    endtask

    // Monitor: compares DUT-presented transactions against queued expectations.
    always @(negedge CLK) begin
        exp_t e;
        logic [15:0] d;
        if (RESET === 1'b1) begin
            if (STACK_PUSH && STACK_READY) begin
                if (q_push.size() == 0) chk("unexpected_push", 32'd1, 32'd0);
                else begin
                    d = q_push.pop_front();
                    chk("push_data", {16'h0, STACK_DATA_OUT}, {16'h0, d});
                end
            end
            if (INT_ACK && !PC_LOAD) chk("ack_without_load", 32'd1, 32'd0);
            if (PC_LOAD) begin
                if (q_pc.size() == 0) chk("unexpected_pc_load", {16'h0, PC_OUT}, 32'hFFFF_FFFF);
                else begin
                    e = q_pc.pop_front();
                    chk("pc_out", {16'h0, PC_OUT}, {16'h0, e.pc});
                    chk("int_ack", {31'h0, INT_ACK}, {31'h0, e.ack});
                end
            end
            if (PC_LOAD8) begin
                if (q_pc8.size() == 0) chk("unexpected_pc_load8", {24'h0, PC_OUT8}, 32'hFFFF_FFFF);
                else begin
                    e = q_pc8.pop_front();
                    chk("pc_out8", {24'h0, PC_OUT8}, {16'h0, e.pc});
                    chk("int_ack8", {31'h0, INT_ACK8}, {31'h0, e.ack});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0; INT2COR = 1'b0; NUM_INT = 4'd0; GIE = 1'b0; INSTR_DONE = 1'b0;
        PC_IN = 16'h0; RETI = 1'b0; STACK_READY = 1'b0; STACK_DATA_IN = 16'h0;
`ifdef INT_MASK_EN
        MASK_WE = 1'b0; MASK_DATA = 16'h0;
`endif
        tick(); tick();
        chk("rst_push", {31'h0, STACK_PUSH}, 32'd0);
        chk("rst_stall", {31'h0, CORE_STALL}, 32'd0);
        chk("rst_pc_out", {16'h0, PC_OUT}, 32'd0);
        chk("rst_active", {28'h0, ACTIVE_NUM}, 32'd0);
        RESET = 1'b1;
        tick();

        // Basic entry: boundary coinciding with request must not count.
        GIE = 1'b1; INT2COR = 1'b1; NUM_INT = 4'd3; INSTR_DONE = 1'b1; PC_IN = 16'h0999;
        tick();
        INT2COR = 1'b0;
        chk("wb_no_push", {31'h0, STACK_PUSH}, 32'd0);
        chk("latched_num3", {28'h0, ACTIVE_NUM}, 32'd3);
        PC_IN = 16'h0123;
        q_push.push_back(16'h0123);
        expect_pc(1'b1, 16'h001C, 8'hFC);
        tick();
        INSTR_DONE = 1'b0;
        chk("push_req", {31'h0, STACK_PUSH}, 32'd1);
        chk("push_stall", {31'h0, CORE_STALL}, 32'd1);
        tick();
        chk("push_held", {31'h0, STACK_PUSH}, 32'd1);
        STACK_READY = 1'b1;
        tick();
        STACK_READY = 1'b0;
        tick();
        chk("in_service", {31'h0, IN_SERVICE}, 32'd1);
        chk("svc_no_load", {31'h0, PC_LOAD}, 32'd0);
        // No nesting.
        INT2COR = 1'b1; NUM_INT = 4'd15;
        tick(); tick();
        chk("svc_ignore_num", {28'h0, ACTIVE_NUM}, 32'd3);
        chk("svc_still", {31'h0, IN_SERVICE}, 32'd1);
        INT2COR = 1'b0;
        RETI = 1'b1;
        tick();
        RETI = 1'b0;
        chk("pop_req", {31'h0, STACK_POP}, 32'd1);
        STACK_READY = 1'b1; STACK_DATA_IN = 16'h0123;
        expect_pc(1'b0, 16'h0123, 8'h23);
        tick();
        STACK_READY = 1'b0;
        tick();
        chk("idle_stall", {31'h0, CORE_STALL}, 32'd0);
        chk("idle_svc", {31'h0, IN_SERVICE}, 32'd0);

        // Ignored events in IDLE.
        GIE = 1'b0; INT2COR = 1'b1; NUM_INT = 4'd5;
        tick(); tick();
        INSTR_DONE = 1'b1;
        tick();
        INSTR_DONE = 1'b0;
        chk("gie0_no_latch", {28'h0, ACTIVE_NUM}, 32'd3);
        chk("gie0_no_push", {31'h0, STACK_PUSH}, 32'd0);
        INT2COR = 1'b0;
        RETI = 1'b1;
        tick();
        RETI = 1'b0;
        chk("reti_idle_no_pop", {31'h0, STACK_POP}, 32'd0);
        tick();
        chk("reti_idle_no_pop2", {31'h0, STACK_POP}, 32'd0);

        // Source drop and GIE drop after commit, long boundary wait.
        GIE = 1'b1; INT2COR = 1'b1; NUM_INT = 4'd7;
        tick();
        INT2COR = 1'b0; GIE = 1'b0; NUM_INT = 4'd2;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wait_no_push", {31'h0, STACK_PUSH}, 32'd0);
            chk("wait_num7", {28'h0, ACTIVE_NUM}, 32'd7);
        end
        INSTR_DONE = 1'b1; PC_IN = 16'h4567;
        q_push.push_back(16'h4567);
        expect_pc(1'b1, 16'h002C, 8'h0C);
        tick();
        INSTR_DONE = 1'b0;
        STACK_READY = 1'b1;
        tick();
        STACK_READY = 1'b0;
        tick();
        chk("svc_after_drop", {31'h0, IN_SERVICE}, 32'd1);
        GIE = 1'b1;

        // Request pending at exit is taken on the IDLE cycle after RESTORE.
        INT2COR = 1'b1; NUM_INT = 4'd15;
        RETI = 1'b1;
        tick();
        RETI = 1'b0;
        STACK_READY = 1'b1; STACK_DATA_IN = 16'h4567;
        expect_pc(1'b0, 16'h4567, 8'h67);
        tick();
        STACK_READY = 1'b0;
        tick();
        tick();
        INT2COR = 1'b0;
        chk("reentry_num15", {28'h0, ACTIVE_NUM}, 32'd15);

        // Interrupt 15: 8-bit instance wraps to 8'h2C.
        INSTR_DONE = 1'b1; PC_IN = 16'h00AB;
        q_push.push_back(16'h00AB);
        expect_pc(1'b1, 16'h004C, 8'h2C);
        tick();
        INSTR_DONE = 1'b0;
        chk("push15", {31'h0, STACK_PUSH}, 32'd1);
        STACK_READY = 1'b1;
        tick();
        STACK_READY = 1'b0;
        tick();
        RETI = 1'b1;
        tick();
        RETI = 1'b0;
        STACK_READY = 1'b1; STACK_DATA_IN = 16'h00AB;
        expect_pc(1'b0, 16'h00AB, 8'hAB);
        tick();
        STACK_READY = 1'b0;
        tick();

        // Reset in the middle of PUSH.
        INT2COR = 1'b1; NUM_INT = 4'd9;
        tick();
        INT2COR = 1'b0;
        INSTR_DONE = 1'b1; PC_IN = 16'h7777;
        tick();
        INSTR_DONE = 1'b0;
        chk("pre_rst_push", {31'h0, STACK_PUSH}, 32'd1);
        RESET = 1'b0;
        #1;
        chk("mid_rst_push", {31'h0, STACK_PUSH}, 32'd0);
        chk("mid_rst_stall", {31'h0, CORE_STALL}, 32'd0);
        chk("mid_rst_data", {16'h0, STACK_DATA_OUT}, 32'd0);
        chk("mid_rst_active", {28'h0, ACTIVE_NUM}, 32'd0);
        STACK_READY = 1'b1;
        tick();
        RESET = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_no_load", {31'h0, PC_LOAD}, 32'd0);
            chk("post_rst_no_push", {31'h0, STACK_PUSH}, 32'd0);
        end
        STACK_READY = 1'b0;

`ifdef INT_MASK_EN
        MASK_WE = 1'b1; MASK_DATA = 16'hFFF7;
        tick();
        MASK_WE = 1'b0;
        INT2COR = 1'b1; NUM_INT = 4'd3;
        tick(); tick();
        chk("mask_block3", {28'h0, ACTIVE_NUM}, 32'd0);
        INSTR_DONE = 1'b1;
        tick();
        INSTR_DONE = 1'b0;
        chk("mask_block3_push", {31'h0, STACK_PUSH}, 32'd0);
        NUM_INT = 4'd4;
        tick();
        INT2COR = 1'b0;
        chk("mask_accept4", {28'h0, ACTIVE_NUM}, 32'd4);
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        tick();
`endif

        chk("q_pc_drained", q_pc.size(), 32'd0);
        chk("q_pc8_drained", q_pc8.size(), 32'd0);
        chk("q_push_drained", q_push.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/int_core_handler.md
INT_CORE_HANDLER -- requirements
Module: int_core_handler

Interface
REQ-001 Parameter PC_WIDTH, default 16: width of every program-counter path.
REQ-002 Parameter VECTOR_BASE, default 16'h0010: address of the vector for interrupt 0.
REQ-003 Parameter VECTOR_STRIDE_LOG2, default 2: log2 of the spacing between vector entries.
REQ-004 CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 RESET  input  1  asynchronous, active-low reset.
REQ-006 INT2COR  input  1  level-type request from the interrupt controller.
REQ-007 NUM_INT  input  4  number of the requesting interrupt; valid when INT2COR is high.
REQ-008 GIE  input  1  global interrupt enable; requests are ignored while low.
REQ-009 INSTR_DONE  input  1  core is at an instruction boundary this cycle.
REQ-010 PC_IN  input  PC_WIDTH  core return address, valid with INSTR_DONE.
REQ-011 RETI  input  1  one-cycle pulse from the core on return-from-interrupt.
REQ-012 STACK_READY  input  1  stack accepts the push, or returns pop data, this cycle.
REQ-013 STACK_DATA_IN  input  PC_WIDTH  pop data, valid with STACK_READY in POP.
REQ-014 STACK_PUSH / STACK_POP  output  1 each  stack requests, held high until STACK_READY.
REQ-015 STACK_DATA_OUT  output  PC_WIDTH  saved return address.
REQ-016 PC_LOAD  output  1  one-cycle pulse telling the core to load PC_OUT.
REQ-017 PC_OUT  output  PC_WIDTH  vector address or restored return address.
REQ-018 CORE_STALL  output  1  freezes the core while the block owns the PC.
REQ-019 INT_ACK  output  1  one-cycle acknowledge pulse to the source.
REQ-020 IN_SERVICE  output  1  a handler is currently running.
REQ-021 ACTIVE_NUM  output  4  number of the interrupt being serviced.

Function
REQ-022 The FSM SHALL have seven states: IDLE, WAIT_BOUND, PUSH, VECTOR, SERVICE, POP, RESTORE.
REQ-023 IDLE: when INT2COR & GIE, latch NUM_INT into ACTIVE_NUM and go to WAIT_BOUND.
REQ-024 WAIT_BOUND: on INSTR_DONE, latch PC_IN into STACK_DATA_OUT and go to PUSH; the request stays committed even if INT2COR falls.
REQ-025 INSTR_DONE is honoured only in WAIT_BOUND; INSTR_DONE in the same cycle as the IDLE request does not count.
REQ-026 PUSH: STACK_PUSH=1 and CORE_STALL=1; on STACK_READY go to VECTOR.
REQ-027 VECTOR: PC_LOAD=1, INT_ACK=1 and CORE_STALL=1 for exactly one cycle, with PC_OUT = VECTOR_BASE + (ACTIVE_NUM << VECTOR_STRIDE_LOG2), truncated modulo 2^PC_WIDTH; then go to SERVICE.
REQ-028 SERVICE: IN_SERVICE=1; INT2COR is ignored (no nesting); on RETI go to POP.
REQ-029 RETI in any state other than SERVICE SHALL be ignored.
REQ-030 POP: STACK_POP=1 and CORE_STALL=1; on STACK_READY capture STACK_DATA_IN and go to RESTORE.
REQ-031 RESTORE: PC_LOAD=1 and CORE_STALL=1 for one cycle, with PC_OUT equal to the popped value; then go to IDLE.
REQ-032 Latency: request at cycle n gives WAIT_BOUND at n+1; INSTR_DONE at cycle m gives PUSH at m+1; STACK_READY at cycle k gives VECTOR at k+1 and SERVICE at k+2.
REQ-033 GIE going low after IDLE SHALL NOT abort an entry that has already started.
REQ-034 A request still present on entering IDLE after RESTORE SHALL be accepted on that IDLE cycle.
REQ-035 Outside the cycles stated above, PC_LOAD, INT_ACK, STACK_PUSH and STACK_POP SHALL be 0.

Reset
REQ-036 RESET low SHALL immediately set the state to IDLE and all outputs, ACTIVE_NUM and all data registers to 0, including mid-operation.
REQ-037 After RESET, no stack or PC transaction begun before the reset SHALL be completed.

Configuration
REQ-038 Macro INT_MASK_EN, when defined, adds inputs MASK_WE (1 bit) and MASK_DATA (16 bits).
  - A 16-bit mask register loads MASK_DATA on MASK_WE and resets to 16'hFFFF (all interrupts enabled).
  - In IDLE a request is accepted only if mask bit [NUM_INT] is 1.
REQ-039 Without INT_MASK_EN, these ports and the mask register SHALL NOT exist, and every NUM_INT is accepted.

Verification
REQ-040 Basic entry: NUM_INT=3, INT2COR=1, then INSTR_DONE with PC_IN=16'h0123, then STACK_READY -> STACK_DATA_OUT=16'h0123; PC_OUT=16'h001C with PC_LOAD and INT_ACK pulsed one cycle; IN_SERVICE=1.
REQ-041 Return: RETI in SERVICE, then STACK_READY with STACK_DATA_IN=16'h0123 -> PC_LOAD pulse with PC_OUT=16'h0123; state returns to IDLE.
REQ-042 Boundary wait and source drop: INT2COR held for 1 cycle, INSTR_DONE 5 cycles later -> entry still completes; ACTIVE_NUM keeps the latched value; no STACK_PUSH before INSTR_DONE.
REQ-043 Ignored events: GIE=0 with INT2COR=1 -> no state change; RETI in IDLE -> no STACK_POP; NUM_INT=15 during SERVICE -> ignored.
REQ-044 Wrap-around: PC_WIDTH=8, VECTOR_BASE=8'hF0, NUM_INT=15 -> PC_OUT=8'h2C.
REQ-045 Reset mid-PUSH: RESET low while STACK_PUSH=1 -> all outputs 0 at once; no PC_LOAD after RESET is released.
  - With INT_MASK_EN: writing mask 16'hFFF7 blocks NUM_INT=3 and still accepts NUM_INT=4.
